// File: rtl/en_de_pkg.sv
`default_nettype none
// ============================================================================
// Module      : en_de_pkg
// Description : Frame geometry and state encoding shared by the encoder,
//               decoder and coefficient serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package en_de_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_t;

  function automatic int calc_num_coeff(input int data_size, input int scale_factor);
    return data_size + scale_factor;
  endfunction

  // One extra code point is reserved for the trailing checksum beat.
  function automatic int calc_idx_width(input int num_coeff);
    return $clog2(num_coeff + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_csum_acc.sv
`default_nettype none
// ============================================================================
// Module      : poly_csum_acc
// Description : Running modulo-2^POLY_SIZE sum of accepted coefficients.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_csum_acc #(
  parameter int POLY_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [POLY_SIZE-1:0] addend,
  output logic [POLY_SIZE-1:0] sum
);

  logic [POLY_SIZE-1:0] r_sum;

  // Carry out of the top bit is intentionally discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (enable) begin
      r_sum <= r_sum + addend;
    end
  end

  assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/poly_coeff_serializer.sv
`default_nettype none
// ============================================================================
// Module      : poly_coeff_serializer
// Description : Buffers one encoded frame and streams its coefficients one
//               per beat, followed by a modular checksum beat.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_coeff_serializer
  import en_de_pkg::*;
#(
  parameter  int DATA_SIZE    = 16,
  parameter  int POLY_SIZE    = 16,
  parameter  int SCALE_FACTOR = 2,
  localparam int NUM_COEFF    = calc_num_coeff(DATA_SIZE, SCALE_FACTOR),
  localparam int FRAME_W      = NUM_COEFF * POLY_SIZE,
  localparam int IDX_W        = calc_idx_width(NUM_COEFF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FRAME_W-1:0]   in_frame,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [POLY_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_COEFF - 1);
  localparam logic [IDX_W-1:0] c_csum_idx = IDX_W'(NUM_COEFF);

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_in_ready;
  logic [POLY_SIZE-1:0] r_coeff    [NUM_COEFF];
  logic [POLY_SIZE-1:0] w_coeff_in [NUM_COEFF];

  logic                 w_in_hs;
  logic                 w_out_hs;
  logic [IDX_W-1:0]     w_sel;
  logic [POLY_SIZE-1:0] w_cur_coeff;
  logic [POLY_SIZE-1:0] w_sum;
  logic [POLY_SIZE-1:0] w_out_data;

  generate
    for (genvar k = 0; k < NUM_COEFF; k++) begin : g_unpack
      assign w_coeff_in[k] = in_frame[k*POLY_SIZE +: POLY_SIZE];
    end
  endgenerate

  // r_in_ready is only ever high in IDLE, so it doubles as the state qualifier.
  assign w_in_hs  = in_valid & r_in_ready;
  assign w_out_hs = r_out_valid & out_ready;

  // Clamp keeps the buffer read in range while the index points at the checksum.
  assign w_sel       = (r_idx > c_last_idx) ? c_last_idx : r_idx;
  assign w_cur_coeff = r_coeff[w_sel];

  poly_csum_acc #(
    .POLY_SIZE (POLY_SIZE)
  ) u_csum (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_in_hs),
    .enable (w_out_hs && (r_state == SEND)),
    .addend (w_cur_coeff),
    .sum    (w_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_in_ready  <= 1'b0;
      for (int k = 0; k < NUM_COEFF; k++) begin
        r_coeff[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_in_hs) begin
            r_coeff     <= w_coeff_in;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (w_out_hs) begin
            if (r_idx == c_last_idx) begin
              r_idx      <= c_csum_idx;
              r_out_last <= 1'b1;
              r_state    <= CSUM;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        CSUM: begin
          if (w_out_hs) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_in_ready  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_out_data = '0;
    case (r_state)
      SEND:    w_out_data = w_cur_coeff;
      CSUM:    w_out_data = w_sum;
      default: w_out_data = '0;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_data  = w_out_data;
  assign out_valid = r_out_valid;
  assign out_idx   = r_idx;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_poly_coeff_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_coeff_serializer
// Description : Self-checking bench for the coefficient serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_coeff_serializer;

  localparam int DATA_SIZE    = 16;
  localparam int POLY_SIZE    = 16;
  localparam int SCALE_FACTOR = 2;
  localparam int NUM_COEFF    = 18;
  localparam int FRAME_W      = NUM_COEFF * POLY_SIZE;
  localparam int IDX_W        = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [FRAME_W-1:0]   in_frame;
  logic                 in_valid;
  logic                 in_ready;
  logic [POLY_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;

  int checks   = 0;
  int failures = 0;

  poly_coeff_serializer #(
    .DATA_SIZE    (DATA_SIZE),
    .POLY_SIZE    (POLY_SIZE),
    .SCALE_FACTOR (SCALE_FACTOR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_frame  (in_frame),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: coeff k = k+1, mode 1: all 0xFFFF, otherwise random
  function automatic logic [FRAME_W-1:0] make_frame(input int mode);
    logic [FRAME_W-1:0] f = '0;
    for (int k = 0; k < NUM_COEFF; k++) begin
      case (mode)
        0:       f[k*POLY_SIZE +: POLY_SIZE] = 16'(k + 1);
        1:       f[k*POLY_SIZE +: POLY_SIZE] = 16'hFFFF;
        default: f[k*POLY_SIZE +: POLY_SIZE] = 16'($urandom);
      endcase
    end
    return f;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic load(input logic [FRAME_W-1:0] f);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("load_in_ready", in_ready, 1);
    in_frame = f;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_frame = {9{$urandom()}};
    check("load_latency_valid", out_valid, 1);
    check("load_in_ready_low", in_ready, 0);
  endtask

  task automatic drain(input logic [FRAME_W-1:0] f, input bit bp, output int csum_seen);
    int exp_data[$];
    int sum  = 0;
    int beat = 0;
    int cyc  = 0;
    for (int k = 0; k < NUM_COEFF; k++) begin
      exp_data.push_back(int'(f[k*POLY_SIZE +: POLY_SIZE]));
      sum = (sum + int'(f[k*POLY_SIZE +: POLY_SIZE])) % 65536;
    end
    exp_data.push_back(sum);
    csum_seen = -1;
    while (beat <= NUM_COEFF && cyc < 400) begin
      check("busy_in_ready", in_ready, 0);
      check("beat_valid", out_valid, 1);
      check("beat_data", out_data, exp_data[beat]);
      check("beat_idx", out_idx, beat);
      check("beat_last", out_last, beat == NUM_COEFF);
      if (beat == NUM_COEFF) csum_seen = int'(out_data);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) beat++;
      @(negedge clk);
      cyc++;
    end
    check("drain_beats", beat, NUM_COEFF + 1);
    out_ready = 1'b0;
    check("post_in_ready", in_ready, 1);
    check("post_valid", out_valid, 0);
  endtask

  task automatic partial(input logic [FRAME_W-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      check("part_data", out_data, f[i*POLY_SIZE +: POLY_SIZE]);
      check("part_idx", out_idx, i);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic [FRAME_W-1:0] fa;
    logic [FRAME_W-1:0] fb;
    int cs;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_frame  = '0;
    out_ready = 1'b0;
    #2;
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst0_release_in_ready", in_ready, 0);
    @(negedge clk);
    check("rst0_in_ready_up", in_ready, 1);

    fa = make_frame(0);
    load(fa);
    drain(fa, 1'b0, cs);
    check("basic_csum", cs, 32'h00AB);

    fa = make_frame(1);
    load(fa);
    drain(fa, 1'b0, cs);
    check("wrap_csum", cs, 32'hFFEE);

    fa = make_frame(0);
    load(fa);
    drain(fa, 1'b1, cs);
    check("bp_csum", cs, 32'h00AB);

    // Second frame held on the input for the whole of the first one.
    fa = make_frame(2);
    fb = make_frame(2);
    load(fa);
    in_frame = fb;
    in_valid = 1'b1;
    drain(fa, 1'b1, cs);
    load(fb);
    drain(fb, 1'b0, cs);

    fa = make_frame(2);
    load(fa);
    partial(fa, 8);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    check("rst_mid_hold_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready_up", in_ready, 1);
    fa = make_frame(2);
    load(fa);
    drain(fa, 1'b0, cs);

    fa = make_frame(2);
    load(fa);
    partial(fa, NUM_COEFF);
    check("csum_stall_last", out_last, 1);
    check("csum_stall_valid", out_valid, 1);
    @(negedge clk);
    check("csum_stall_hold_idx", out_idx, NUM_COEFF);
    #3 reset = 1'b1;
    #1 check_reset_outputs("rst_csum");
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_csum_no_beat", out_valid, 0);
    end
    out_ready = 1'b0;
    check("rst_csum_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      fa = make_frame(2);
      load(fa);
      drain(fa, 1'($urandom_range(0, 1)), cs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
